cc_frame_controller: RTL and testbench
======================================

// Module: cc_frame_controller
// PURPOSE
//  Frame sequencer between the CipherCore UART receive path and the cipher datapath.
//  Parses the received byte stream into command, optional key and data block.
//  Launches the cipher core and waits for its result.
//  Streams the result bytes to the UART transmitter. Runs in the 30 MHz core clock domain.
// PARAMETERS
//  KEY_BYTES     4      key length in bytes (>=1)
//  BLK_BYTES     4      data block length in bytes (>=1)
//  TIMEOUT_CYC   30000  max idle cycles between bytes of one frame (1 ms @ 30 MHz)
// PORTS
//  clk        in   1             core clock; single clock domain
//  rst        in   1             asynchronous, active-high reset
//  rx_data    in   8             received byte; valid only while rx_valid=1
//  rx_valid   in   1             1-cycle strobe per received byte
//  core_start out  1             1-cycle pulse: launch cipher operation
//  core_mode  out  1             0=encrypt, 1=decrypt; stable from core_start to core_done
//  core_key   out  8*KEY_BYTES   stored key; first received key byte in MSBs
//  core_din   out  8*BLK_BYTES   data block; first received data byte in MSBs
//  core_done  in   1             1-cycle pulse: core_dout valid this cycle
//  core_dout  in   8*BLK_BYTES   cipher result
//  tx_data    out  8             byte to transmit
//  tx_valid   out  1             tx_data valid; held until accepted
//  tx_ready   in   1             transmitter accepts on tx_valid&tx_ready
//  busy       out  1             high in any state other than IDLE
//  err        out  1             1-cycle pulse on bad command, timeout or overrun
// BEHAVIOUR
//  Reset: all outputs 0; key, data and result registers cleared; state=IDLE.
//  Command byte: [7:4] must be 4'hC (sync); [1]=load_key; [0]=mode. [3:2] are ignored.
//  States and transitions:
//   IDLE : rx_valid with valid sync -> latch mode; go KEY if load_key, else DATA.
//          Invalid sync -> byte dropped, err pulse, stay IDLE.
//   KEY  : shift in KEY_BYTES bytes into key reg (MSB first), then go DATA.
//   DATA : shift in BLK_BYTES bytes into core_din (MSB first), then go START.
//   START: core_start=1 for exactly one cycle, then go WAIT.
//          core_start asserts the cycle after the rx_valid of the last data byte.
//   WAIT : on core_done, capture core_dout and go SEND.
//          tx_valid rises the next cycle carrying the MSB byte. No timeout in WAIT.
//   SEND : present bytes MSB first. A byte is accepted when tx_valid&tx_ready; the next byte follows next cycle.
//          After the last byte is accepted -> IDLE; tx_valid=0 that next cycle.
//  Key register persists across frames. A frame without load_key reuses the last key (0 after reset).
//  A new key is written to core_key only as KEY bytes arrive.
//   A partial key from an aborted frame remains; the host must resend the key.
//  Timeout: counter cleared on every accepted byte, counts only in KEY/DATA.
//   Reaching TIMEOUT_CYC-1 -> err pulse, go IDLE, data register retained but unused.
//   If rx_valid and expiry occur in the same cycle, the byte wins and the counter clears.
//  Overrun: rx_valid in START/WAIT/SEND -> byte dropped, err pulse, state unaffected.
//  core_done outside WAIT is ignored.
//  Byte counter width: $clog2(max(KEY_BYTES,BLK_BYTES)+1); cleared on every state entry.
//  Asynchronous reset mid-frame or mid-SEND aborts immediately; no partial tx byte is retained.
// STRUCTURE
//  cc_pkg: state localparams (IDLE..SEND), CMD_SYNC=4'hC, CMD_LOADKEY_BIT=1, CMD_MODE_BIT=0.
//  Sub-module cc_timeout_ctr (clear, enable, expire pulse; parameter TIMEOUT_CYC).
//  Everything else is inline: FSM, byte counter, shift registers and tx output mux.
// TESTING
//  1 Reset: assert rst mid-DATA -> all outputs 0, busy=0; next valid frame processes normally.
//  2 Keyed encrypt, KEY_BYTES=BLK_BYTES=4:
//     bytes C2,01,02,03,04,AA,BB,CC,DD -> core_key=01020304, core_din=AABBCCDD.
//     core_mode=0; core_start pulses 1 cycle after DD.
//     Model returns 11223344 -> tx 11,22,33,44 in order.
//  3 Keyless decrypt: C1,55,66,77,88 -> core_key unchanged (01020304), core_mode=1.
//     tx_ready held low 10 cycles -> tx_valid/tx_data held stable until accepted.
//  4 Bad command 7F in IDLE -> err 1 cycle, busy stays 0.
//     Bytes after the timeout in test 5 are parsed as a new frame.
//  5 Timeout: C0,11 then silence TIMEOUT_CYC cycles -> err pulse, busy=0.
//     A byte on the expiry cycle is accepted instead and the frame continues.
//  6 Overrun: inject byte during WAIT -> err pulse; result unaffected.
//     core_done pulsed in IDLE -> no tx activity.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared definitions for the CipherCore frame controller.
package cc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_DATA  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_SEND  = 3'd5
  } state_t;

  localparam logic [3:0]  CMD_SYNC        = 4'hC;
  localparam int unsigned CMD_LOADKEY_BIT = 1;
  localparam int unsigned CMD_MODE_BIT    = 0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cc_timeout_ctr.sv
// Inter-byte idle counter; expire is high while the count sits at TIMEOUT_CYC-1.
module cc_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 30000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // Count idle cycles while enabled; any accepted byte or leaving KEY/DATA restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clear || !enable)  cnt <= '0;
    else if (cnt != LAST)       cnt <= cnt + 1'b1;
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/cc_frame_controller.sv
// Frame sequencer: parses UART bytes into command/key/data, runs the cipher core,
// and streams the result back to the UART transmitter MSB first.
module cc_frame_controller
  import cc_pkg::*;
#(
  parameter int unsigned KEY_BYTES   = 4,
  parameter int unsigned BLK_BYTES   = 4,
  parameter int unsigned TIMEOUT_CYC = 30000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   core_start,
  output logic                   core_mode,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*BLK_BYTES-1:0] core_din,
  input  logic                   core_done,
  input  logic [8*BLK_BYTES-1:0] core_dout,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned KW = 8 * KEY_BYTES;
  localparam int unsigned BW = 8 * BLK_BYTES;
  localparam int unsigned CW = $clog2(max_u(KEY_BYTES, BLK_BYTES) + 1);
  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLK_BYTES - 1);

  state_t        state, state_next;
  logic [CW-1:0] byte_cnt;
  logic [BW-1:0] result;
  logic          cnt_inc, key_shift, din_shift, mode_load, res_load, res_shift;
  logic          err_next, tmo_en, tmo_expire;

  cc_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control; a byte arriving on the expiry cycle takes priority.
  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    key_shift  = 1'b0;
    din_shift  = 1'b0;
    mode_load  = 1'b0;
    res_load   = 1'b0;
    res_shift  = 1'b0;
    err_next   = 1'b0;
    tmo_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:4] == CMD_SYNC) begin
            mode_load  = 1'b1;
            state_next = rx_data[CMD_LOADKEY_BIT] ? ST_KEY : ST_DATA;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_KEY: begin
        tmo_en = 1'b1;
        if (rx_valid) begin
          key_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (byte_cnt == KEY_LAST) state_next = ST_DATA;
        end else if (tmo_expire) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        tmo_en = 1'b1;
        if (rx_valid) begin
          din_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (byte_cnt == BLK_LAST) state_next = ST_START;
        end else if (tmo_expire) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_START: begin
        err_next   = rx_valid;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        err_next = rx_valid;
        if (core_done) begin
          res_load   = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        err_next = rx_valid;
        if (tx_ready) begin
          res_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (byte_cnt == BLK_LAST) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Byte counter, shift registers, mode latch and registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      core_key  <= '0;
      core_din  <= '0;
      core_mode <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      err <= err_next;
      if (state_next != state) byte_cnt <= '0;
      else if (cnt_inc)        byte_cnt <= byte_cnt + 1'b1;
      if (mode_load) core_mode <= rx_data[CMD_MODE_BIT];
      if (key_shift) core_key  <= (core_key << 8) | KW'(rx_data);
      if (din_shift) core_din  <= (core_din << 8) | BW'(rx_data);
      if (res_load)       result <= core_dout;
      else if (res_shift) result <= result << 8;
    end
  end

  assign core_start = (state == ST_START);
  assign busy       = (state != ST_IDLE);
  assign tx_valid   = (state == ST_SEND);
  // The result is shifted toward the MSB byte as bytes are accepted, so the top byte is always next.
  assign tx_data    = tx_valid ? result[BW-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_cc_frame_controller.sv
// Scoreboard bench for cc_frame_controller with a small cipher-core responder.
module tb_cc_frame_controller;

  localparam int unsigned KB       = 4;
  localparam int unsigned BB       = 4;
  localparam int unsigned TO       = 64;
  localparam int unsigned CORE_LAT = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          core_start;
  logic          core_mode;
  logic [8*KB-1:0] core_key;
  logic [8*BB-1:0] core_din;
  logic          core_done;
  logic [8*BB-1:0] core_dout;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          err;

  int unsigned   vectors     = 0;
  int unsigned   miscompares = 0;
  int unsigned   err_cnt     = 0;
  int unsigned   starts      = 0;
  int unsigned   idle_done_reqs = 0;
  logic [8*BB-1:0] resp = '0;
  logic [7:0]    exp_q[$];

  cc_frame_controller #(.KEY_BYTES(KB), .BLK_BYTES(BB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .core_start(core_start), .core_mode(core_mode), .core_key(core_key), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Transmit monitor: pop expected bytes on each accepted transfer.
  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (err) err_cnt++;
      if (!rst && tx_valid && tx_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_unexpected got=%02h required=none", tx_data);
        end else begin
          eb = exp_q.pop_front();
          if (tx_data !== eb) begin
            miscompares++;
            $display("FAIL tx_byte got=%02h required=%02h", tx_data, eb);
          end
        end
      end
    end
  end

  // Cipher core responder: answers each start with resp after CORE_LAT cycles.
  initial begin
    int unsigned served = 0;
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        starts++;
        repeat (CORE_LAT) @(posedge clk);
        #1 core_dout = resp; core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
      end else if (idle_done_reqs != served) begin
        served++;
        @(posedge clk);
        #1 core_dout = 32'h5A5A5A5A; core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1; rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic push_resp(input logic [8*BB-1:0] r);
    resp = r;
    for (int i = 0; i < int'(BB); i++) exp_q.push_back(r[8*BB-1-8*i -: 8]);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL idle_wait got=busy:%0b queued:%0d required=idle", busy, exp_q.size());
    end
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_valid_after_last got=%0b required=0", tx_valid);
    end
  endtask

  // Check key/data/mode and start pulse right after the final data byte.
  task automatic check_launch(input string name, input logic [8*KB-1:0] k,
                              input logic [8*BB-1:0] d, input logic m);
    @(negedge clk);
    vectors++;
    if ({core_start, core_mode, core_key, core_din} !== {1'b1, m, k, d}) begin
      miscompares++;
      $display("FAIL %s_launch got=start:%0b mode:%0b key:%08h din:%08h required=start:1 mode:%0b key:%08h din:%08h",
               name, core_start, core_mode, core_key, core_din, m, k, d);
    end
    @(negedge clk);
    vectors++;
    if (core_start !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_start_width got=%0b required=0", name, core_start);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    #15;
    vectors++;
    if ({core_start, core_mode, tx_valid, busy, err, tx_data, core_key, core_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%0h required=0",
               {core_start, core_mode, tx_valid, busy, err, tx_data, core_key, core_din});
    end
    @(negedge clk); rst = 1'b0;
    send_byte(8'hC1); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_data_busy got=%0b required=1", busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({core_start, core_mode, tx_valid, busy, err, tx_data, core_key, core_din} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs got=%0h required=0",
               {core_start, core_mode, tx_valid, busy, err, tx_data, core_key, core_din});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_keyed_encrypt();
    int unsigned s0 = starts;
    push_resp(32'h11223344);
    send_byte(8'hC2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check_launch("keyed", 32'h01020304, 32'hAABBCCDD, 1'b0);
    wait_idle();
    vectors++;
    if (starts - s0 != 1) begin
      miscompares++;
      $display("FAIL keyed_start_count got=%0d required=1", starts - s0);
    end
  endtask

  task automatic test_keyless_decrypt();
    bit stable = 1;
    bit seen = 0;
    push_resp(32'hCAFEBABE);
    tx_ready = 1'b0;
    send_byte(8'hC1);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check_launch("keyless", 32'h01020304, 32'h55667788, 1'b1);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    for (int k = 0; k < 10; k++) begin
      if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) stable = 0;
      if (k != 9) @(negedge clk);
    end
    vectors++;
    if (!(seen && stable)) begin
      miscompares++;
      $display("FAIL stall_hold got=seen:%0b valid:%0b data:%02h required=valid:1 data:%02h",
               seen, tx_valid, tx_data, exp_q[0]);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h7F);
    @(negedge clk);
    vectors++;
    if ({err, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL bad_cmd got=err:%0b busy:%0b required=err:1 busy:0", err, busy);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_cmd_width got=%0b required=0", err);
    end
  endtask

  task automatic test_timeout();
    int unsigned at = 0;
    int unsigned e0;
    send_byte(8'hC0); send_byte(8'h11);
    for (int n = 1; n <= int'(2 * TO) && at == 0; n++) begin
      @(posedge clk); #1;
      if (err) at = n;
    end
    vectors++;
    if (at != TO || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_cycle got=cycle:%0d busy:%0b required=cycle:%0d busy:0", at, busy, TO);
    end
    // Bytes after the timeout form a fresh frame.
    push_resp(32'h0F1E2D3C);
    send_byte(8'hC0);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
    check_launch("post_timeout", 32'h01020304, 32'h21222324, 1'b0);
    wait_idle();
    // A byte landing on the expiry cycle is taken and the frame continues.
    e0 = err_cnt;
    push_resp(32'h99887766);
    send_byte(8'hC0); send_byte(8'h11);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h22);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL expiry_byte got=busy:%0b errs:%0d required=busy:1 errs:0", busy, err_cnt - e0);
    end
    send_byte(8'h33); send_byte(8'h44);
    check_launch("expiry_byte", 32'h01020304, 32'h11223344, 1'b0);
    wait_idle();
  endtask

  task automatic test_overrun();
    int unsigned e0;
    bit quiet = 1;
    push_resp(32'hDEADBEEF);
    send_byte(8'hC0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    e0 = err_cnt;
    @(posedge clk);
    send_byte(8'h99);
    repeat (2) @(negedge clk);
    vectors++;
    if (err_cnt - e0 != 1 || busy !== 1'b1 || core_din !== 32'h01020304) begin
      miscompares++;
      $display("FAIL overrun got=errs:%0d busy:%0b din:%08h required=errs:1 busy:1 din:01020304",
               err_cnt - e0, busy, core_din);
    end
    wait_idle();
    idle_done_reqs++;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (tx_valid || busy) quiet = 0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL idle_core_done got=activity required=none");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_keyed_encrypt();
    test_keyless_decrypt();
    test_bad_cmd();
    test_timeout();
    test_overrun();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
